// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg
//   Shared definitions for the data-memory responder and its users.
//   - WD_SIZE           : data/address word width of the memory request bus
//   - dmem_resp_state_t : responder FSM states (IDLE accepts, BUSY counts down)
//   - keep_merge()      : per-bit write merge, also used by the memory stage
//                         when formatting stores
package dmem_responder_pkg;

  localparam int WD_SIZE = 32;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } dmem_resp_state_t;

  // Bits set in keep take the new data, cleared bits keep the old value.
  function automatic logic [WD_SIZE-1:0] keep_merge(
    input logic [WD_SIZE-1:0] old,
    input logic [WD_SIZE-1:0] data,
    input logic [WD_SIZE-1:0] keep
  );
    return (old & ~keep) | (data & keep);
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if
//   Request/response bus between the memory stage (master) and the
//   data-memory responder (slave).
//   Request : req_valid_i, req_wr_i, req_addr_i, req_wr_data_i, req_wr_keep_i
//   Response: req_ready_o, rsp_valid_o, rsp_rd_data_o, rsp_err_o
//   Signal suffixes are from the responder's point of view.
interface dmem_responder_if;
  import dmem_responder_pkg::*;

  logic               req_valid_i;
  logic               req_wr_i;
  logic [WD_SIZE-1:0] req_addr_i;
  logic [WD_SIZE-1:0] req_wr_data_i;
  logic [WD_SIZE-1:0] req_wr_keep_i;
  logic               req_ready_o;
  logic               rsp_valid_o;
  logic [WD_SIZE-1:0] rsp_rd_data_o;
  logic               rsp_err_o;

  modport master (
    output req_valid_i, req_wr_i, req_addr_i, req_wr_data_i, req_wr_keep_i,
    input  req_ready_o, rsp_valid_o, rsp_rd_data_o, rsp_err_o
  );

  modport slave (
    input  req_valid_i, req_wr_i, req_addr_i, req_wr_data_i, req_wr_keep_i,
    output req_ready_o, rsp_valid_o, rsp_rd_data_o, rsp_err_o
  );

endinterface

// File: rtl/dmem_responder.sv
// dmem_responder
//   Multi-cycle data memory with a request/response handshake and a fixed,
//   parameterised access latency. One request is outstanding at a time; a
//   request accepted at edge E0 is answered with a one-cycle rsp_valid_o
//   pulse after edge E(LATENCY). Misaligned or out-of-range accesses are
//   rejected with rsp_err_o and never touch the store.
//
//   Parameters
//     MEM_SIZE_BYTES : store size in bytes (multiple of 4)
//     LATENCY        : accept-to-response cycles, 1..15
//   Ports
//     clk         : clock, rising edge
//     reset       : synchronous active-high reset; reloads the store
//     init_data_i : preload image, byte 0 = address 0
//     bus         : request/response bus (slave side)
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int MEM_SIZE_BYTES = 128,
  parameter int LATENCY        = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [MEM_SIZE_BYTES*8-1:0] init_data_i,
  dmem_responder_if.slave             bus
);

  localparam int AW = $clog2(MEM_SIZE_BYTES);

  dmem_resp_state_t   state;
  logic [3:0]         count;
  logic               lat_wr;
  logic [WD_SIZE-1:0] lat_addr;
  logic [WD_SIZE-1:0] lat_data;
  logic [WD_SIZE-1:0] lat_keep;

  logic [7:0]         store [MEM_SIZE_BYTES];

  logic               access_err;
  logic [AW-1:0]      base;
  logic [WD_SIZE-1:0] old_word;
  logic [WD_SIZE-1:0] new_word;

  // Ready depends on state alone so there is no combinational path from
  // req_valid_i back to the requester.
  assign bus.req_ready_o = (state == IDLE);

  // The error check gates the index: a rejected address collapses to byte 0
  // so the store is never addressed outside its bounds.
  always_comb begin
    access_err = (lat_addr[1:0] != 2'b00) ||
                 (lat_addr > WD_SIZE'(MEM_SIZE_BYTES - 4));
    base       = access_err ? '0 : lat_addr[AW-1:0];
    old_word   = {store[base + AW'(3)], store[base + AW'(2)],
                  store[base + AW'(1)], store[base]};
    new_word   = keep_merge(old_word, lat_data, lat_keep);
  end

  // Single FSM: IDLE latches a request, BUSY counts LATENCY-1 down to 0 and
  // then performs the access (a write is read-modify-write on this edge),
  // registers the response and returns to IDLE. Reset drops any in-flight
  // request and restores the preload image.
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      count             <= '0;
      lat_wr            <= 1'b0;
      lat_addr          <= '0;
      lat_data          <= '0;
      lat_keep          <= '0;
      bus.rsp_valid_o   <= 1'b0;
      bus.rsp_err_o     <= 1'b0;
      bus.rsp_rd_data_o <= '0;
      for (int i = 0; i < MEM_SIZE_BYTES; i++) begin
        store[i] <= init_data_i[8*i +: 8];
      end
    end else begin
      bus.rsp_valid_o <= 1'b0;
      bus.rsp_err_o   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid_i) begin
            lat_wr   <= bus.req_wr_i;
            lat_addr <= bus.req_addr_i;
            lat_data <= bus.req_wr_data_i;
            lat_keep <= bus.req_wr_keep_i;
            count    <= 4'(LATENCY - 1);
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (count != 4'd0) begin
            count <= count - 4'd1;
          end else begin
            state           <= IDLE;
            bus.rsp_valid_o <= 1'b1;
            if (access_err) begin
              bus.rsp_err_o     <= 1'b1;
              bus.rsp_rd_data_o <= '0;
            end else if (lat_wr) begin
              // An all-zero keep rewrites the old bytes, leaving the store unchanged.
              bus.rsp_rd_data_o <= new_word;
              for (int b = 0; b < 4; b++) begin
                store[base + AW'(b)] <= new_word[8*b +: 8];
              end
            end else begin
              bus.rsp_rd_data_o <= old_word;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder: the target side of the data-memory request interface driven by the memory stage (enable, read/write, address, write data, write bit-mask → read data). It replaces the zero-latency data memory with a request/response handshake and a programmable access latency. It also adds back-pressure (`req_ready_o`) and error reporting for misaligned or out-of-range accesses, so the memory stage can be stalled realistically.

## Interface
- `MEM_SIZE_BYTES`, 128: backing store size in bytes; a multiple of 4.
- `LATENCY`, 2: cycles from request acceptance to response; legal range 1..15.
- `clk` in 1: clock; all logic on the rising edge.
- `reset` in 1: reset; synchronous, active-high (already decided).
- `req_valid_i` in 1: request present; counts as accepted only when `req_ready_o`=1.
- `req_wr_i` in 1: 0 = read, 1 = write.
- `req_addr_i` in WD_SIZE: byte address.
- `req_wr_data_i` in WD_SIZE: write data, word-aligned lanes.
- `req_wr_keep_i` in WD_SIZE: per-bit write mask; 1 = overwrite the bit.
- `req_ready_o` out 1: responder idle and able to accept.
- `rsp_valid_o` out 1: one-cycle pulse when the response is ready.
- `rsp_rd_data_o` out WD_SIZE: response data.
- `rsp_err_o` out 1: qualified by `rsp_valid_o`; access rejected.
- `init_data_i` in MEM_SIZE_BYTES×8: preload image, byte 0 = address 0.

## Operation
- States are `IDLE` and `BUSY`. `req_ready_o` = (state == `IDLE`).
- **Reset:**
  - The store is loaded from `init_data_i`.
  - State goes to `IDLE` and the counter to 0.
  - `rsp_valid_o`=0, `rsp_err_o`=0, `rsp_rd_data_o`=0.
  - Reset overrides everything. An in-flight request is dropped with no response, and a pending write never reaches the store.
- **Accept (`IDLE` & `req_valid_i`):**
  - Latch wr, addr, data and keep.
  - Counter ← LATENCY−1; state → `BUSY`.
  - Request inputs are ignored while in `BUSY`.
- **`BUSY`, counter ≠ 0:** decrement the counter.
- **`BUSY`, counter = 0:** perform the access, register the response, state → `IDLE`.
- **Error check:** an access is an error if addr[1:0] ≠ 0 or addr > MEM_SIZE_BYTES−4.
  - On error: no store update, `rsp_err_o`=1, `rsp_rd_data_o`=0.
- **Read:** `rsp_rd_data_o` = little-endian word at bytes addr..addr+3.
- **Write:**
  - new = (old & ~keep) | (wr_data & keep), stored little-endian.
  - `rsp_rd_data_o` = new.
  - An all-zero keep leaves the store unchanged and returns old.
- `rsp_valid_o` and `rsp_err_o` deassert the cycle after the pulse. `rsp_rd_data_o` holds its value until the next response.
- Ordering is strictly in order with one outstanding request. A read after a write to the same word returns the written data.

## Timing
- Request accepted at edge E0 → response registered at edge E(LATENCY) → `rsp_valid_o` high for the one cycle following E(LATENCY).
- `req_ready_o` is low from after E0 through E(LATENCY). It is high again in the `rsp_valid_o` cycle, so the next accept can happen at E(LATENCY+1).
- Maximum throughput: one request per LATENCY+1 cycles.
- `req_ready_o` is a combinational function of state only, with no path from `req_valid_i`.
- A read costs a single store port; a write is a read-modify-write in the same edge.
- If `reset` is asserted in the same cycle as an accept, reset wins: no accept, state `IDLE`.

## Structure
- `PARAMS_pkg` gains two items:
  - `dmem_resp_state_t` (`IDLE`, `BUSY`).
  - Function `keep_merge(old, data, keep)`; the memory stage reuses it for store formatting.
- WD_SIZE comes from `PARAMS_pkg`.
- Single module, no sub-modules. The store is a byte array indexed by addr, with the error check done before indexing so nothing is ever accessed out of range.
- Estimated size: ~150–200 lines.

## Test plan
- **Preload/read:** init bytes 0..3 = 0x78,0x56,0x34,0x12, LATENCY=2; read addr 0 accepted at E0 → `rsp_valid_o` after E2, data 0x12345678, err 0, `req_ready_o` low for exactly 2 cycles.
- **Masked write then read:** write 0xAABBCCDD, keep 0x0000FFFF, to addr 0 (old 0x12345678) → response data 0x1234CCDD; subsequent read of addr 0 → 0x1234CCDD.
- **Errors:** read addr 0x2 → err 1, data 0; write to addr MEM_SIZE_BYTES → err 1 and the store is unchanged (verified by reading all words).
- **Back-to-back with LATENCY=1:** `req_valid_i` held high with 4 reads → accepts every 2nd edge and exactly 4 `rsp_valid_o` pulses; requests presented while busy are ignored.
- **Reset mid-operation:** accept a write of 0xFFFFFFFF to addr 4, assert `reset` while `BUSY` → no `rsp_valid_o`, `req_ready_o`=1 the cycle after reset, addr 4 holds its init value.
- **Latency sweep:** LATENCY ∈ {1, 3, 15}, one read each → `rsp_valid_o` exactly LATENCY cycles after accept.
